pip_frame_stage: RTL and testbench

PIP_FRAME_STAGE -- requirements
Module: pip_frame_stage

---
 rtl/pip_frame_stage_if.sv | 29 ++
 rtl/pip_frame_stage.sv | 147 ++++++++++++++
 tb/tb_pip_frame_stage.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pip_frame_stage_if.sv
// AXI-Stream beat bundle used on both sides of pip_frame_stage.
// master drives the beat and receives back-pressure; slave is the mirror.
interface pip_frame_stage_if #(
  parameter int unsigned DATA_W = 256
);
  localparam int unsigned KEEP_W = DATA_W / 8;

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/pip_frame_stage.sv
// Frame-gated AXI-Stream register pipeline: DEPTH full-throughput stages, an input
// gate that closes after each accepted frame until start, and output frame counting.
module pip_frame_stage #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned KEEP_W = DATA_W / 8,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             aclk,
  input  logic             nrst,
  pip_frame_stage_if.slave  s_axis,
  pip_frame_stage_if.master m_axis,
  input  logic             start,
  output logic             gate_open,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int unsigned LAST = DEPTH - 1;

  // Elaboration-time guard on the legal parameter space.
  if ((DATA_W < 8) || (DATA_W > 1024) || ((DATA_W % 8) != 0)) begin : g_bad_data_w
    $error("pip_frame_stage: DATA_W must be a multiple of 8 in 8..1024");
  end
  if ((DEPTH < 1) || (DEPTH > 8)) begin : g_bad_depth
    $error("pip_frame_stage: DEPTH must be in 1..8");
  end
  if (KEEP_W != (DATA_W / 8)) begin : g_bad_keep_w
    $error("pip_frame_stage: KEEP_W must equal DATA_W/8");
  end

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_CLOSED = 1'b1
  } gate_t;

  gate_t             gate_q;
  logic              run_q;
  logic              s_hs;
  logic              m_hs;
  logic [DEPTH-1:0]  can_load;
  logic [DEPTH-1:0]  stg_vld;
  logic [DATA_W-1:0] stg_data [DEPTH];
  logic [KEEP_W-1:0] stg_keep [DEPTH];
  logic              stg_last [DEPTH];

  // A stage may load when it is empty or its content moves on this same cycle.
  always_comb begin
    can_load       = '0;
    can_load[LAST] = ~stg_vld[LAST] | m_axis.tready;
    for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
      can_load[k] = ~stg_vld[k] | can_load[k+1];
    end
  end

  assign s_axis.tready = run_q & (gate_q == ST_OPEN) & can_load[0];
  assign s_hs          = s_axis.tvalid & s_axis.tready;
  assign m_hs          = m_axis.tvalid & m_axis.tready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic              nxt_vld;
    logic [DATA_W-1:0] nxt_data;
    logic [KEEP_W-1:0] nxt_keep;
    logic              nxt_last;
    logic              vld_q;
    logic [DATA_W-1:0] data_q;
    logic [KEEP_W-1:0] keep_q;
    logic              last_q;

    if (k == 0) begin : g_head
      assign nxt_vld  = s_hs;
      assign nxt_data = s_axis.tdata;
      assign nxt_keep = s_axis.tkeep;
      assign nxt_last = s_axis.tlast;
    end else begin : g_body
      assign nxt_vld  = stg_vld[k-1];
      assign nxt_data = stg_data[k-1];
      assign nxt_keep = stg_keep[k-1];
      assign nxt_last = stg_last[k-1];
    end

    // Loading a bubble (nxt_vld=0) is how a stage empties.
    always_ff @(posedge aclk or negedge nrst) begin
      if (!nrst) begin
        vld_q  <= 1'b0;
        data_q <= '0;
        keep_q <= '0;
        last_q <= 1'b0;
      end else if (can_load[k]) begin
        vld_q  <= nxt_vld;
        data_q <= nxt_data;
        keep_q <= nxt_keep;
        last_q <= nxt_last;
      end
    end

    assign stg_vld[k]  = vld_q;
    assign stg_data[k] = data_q;
    assign stg_keep[k] = keep_q;
    assign stg_last[k] = last_q;
  end

  assign m_axis.tvalid = stg_vld[LAST];
  assign m_axis.tdata  = stg_data[LAST];
  assign m_axis.tkeep  = stg_keep[LAST];
  assign m_axis.tlast  = stg_last[LAST];

  // Input gate; run_q keeps s_tready low until the first edge out of reset.
  always_ff @(posedge aclk or negedge nrst) begin
    if (!nrst) begin
      gate_q <= ST_OPEN;
      run_q  <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (gate_q)
        ST_OPEN: begin
          // A start coinciding with the closing beat keeps the gate open.
          if (s_hs && s_axis.tlast && !start) begin
            gate_q <= ST_CLOSED;
          end
        end
        ST_CLOSED: begin
          if (start) begin
            gate_q <= ST_OPEN;
          end
        end
        default: gate_q <= ST_OPEN;
      endcase
    end
  end

  assign gate_open = (gate_q == ST_OPEN);

  // Completed-frame pulse and wrapping counter, one cycle after the tlast handshake.
  always_ff @(posedge aclk or negedge nrst) begin
    if (!nrst) begin
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= m_hs & m_axis.tlast;
      if (m_hs && m_axis.tlast) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pip_frame_stage.sv
// Bench for pip_frame_stage: queue scoreboard plus gate/frame-count model,
// driven by directed and randomized scenarios.
module tb_pip_frame_stage;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned DEPTH  = 3;
  localparam int unsigned CNT_W  = 2;

  logic             aclk = 1'b0;
  logic             nrst = 1'b0;
  logic             start = 1'b0;
  logic             gate_open;
  logic             frame_done;
  logic [CNT_W-1:0] frame_cnt;

  pip_frame_stage_if #(.DATA_W(DATA_W)) s_axis ();
  pip_frame_stage_if #(.DATA_W(DATA_W)) m_axis ();

  pip_frame_stage #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .aclk      (aclk),
    .nrst      (nrst),
    .s_axis    (s_axis),
    .m_axis    (m_axis),
    .start     (start),
    .gate_open (gate_open),
    .frame_done(frame_done),
    .frame_cnt (frame_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    int                cyc;
  } beat_t;

  beat_t expq[$];
  int    nchk = 0;
  int    nbad = 0;
  int    nout = 0;
  int    cyc  = 0;
  bit    lat_chk = 1'b0;

  int    exp_cnt = 0;
  bit    exp_open = 1'b1;
  bit    prev_done = 1'b0;
  bit    prev_stall = 1'b0;
  beat_t prev_beat;

  always @(posedge aclk) cyc++;

  // Reference model: beats in = beats out in order; gate and frame counter by rule.
  always @(negedge aclk) begin
    bit    in_hs;
    bit    out_hs;
    beat_t b;
    beat_t e;
    if (!nrst) begin
      expq.delete();
      exp_open   = 1'b1;
      exp_cnt    = 0;
      prev_done  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      nchk++;
      if (frame_done !== prev_done) begin
        nbad++;
        $display("FAIL sb_frame_done: got %0b want %0b at cyc %0d", frame_done, prev_done, cyc);
      end
      nchk++;
      if (frame_cnt !== CNT_W'(exp_cnt)) begin
        nbad++;
        $display("FAIL sb_frame_cnt: got %0d want %0d at cyc %0d", frame_cnt, exp_cnt, cyc);
      end
      nchk++;
      if (gate_open !== exp_open) begin
        nbad++;
        $display("FAIL sb_gate_open: got %0b want %0b at cyc %0d", gate_open, exp_open, cyc);
      end
      if (!exp_open) begin
        nchk++;
        if (s_axis.tready !== 1'b0) begin
          nbad++;
          $display("FAIL sb_closed_ready: got %0b want 0 at cyc %0d", s_axis.tready, cyc);
        end
      end
      if (prev_stall) begin
        nchk++;
        if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== prev_beat.data ||
            m_axis.tkeep !== prev_beat.keep || m_axis.tlast !== prev_beat.last) begin
          nbad++;
          $display("FAIL sb_stall_stable: got v%0b %0h/%0h/%0b want v1 %0h/%0h/%0b at cyc %0d",
                   m_axis.tvalid, m_axis.tdata, m_axis.tkeep, m_axis.tlast,
                   prev_beat.data, prev_beat.keep, prev_beat.last, cyc);
        end
      end

      in_hs  = (s_axis.tvalid === 1'b1) && (s_axis.tready === 1'b1);
      out_hs = (m_axis.tvalid === 1'b1) && (m_axis.tready === 1'b1);

      if (out_hs) begin
        nout++;
        nchk++;
        if (expq.size() == 0) begin
          nbad++;
          $display("FAIL sb_extra_beat: got %0h with no expected beat at cyc %0d", m_axis.tdata, cyc);
        end else begin
          e = expq.pop_front();
          if (m_axis.tdata !== e.data || m_axis.tkeep !== e.keep || m_axis.tlast !== e.last) begin
            nbad++;
            $display("FAIL sb_beat: got %0h/%0h/%0b want %0h/%0h/%0b at cyc %0d",
                     m_axis.tdata, m_axis.tkeep, m_axis.tlast, e.data, e.keep, e.last, cyc);
          end
          if (lat_chk) begin
            nchk++;
            if (cyc - e.cyc !== int'(DEPTH)) begin
              nbad++;
              $display("FAIL sb_latency: got %0d want %0d", cyc - e.cyc, DEPTH);
            end
          end
        end
      end

      prev_done = out_hs && (m_axis.tlast === 1'b1);
      if (prev_done) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);

      if (in_hs && s_axis.tlast && !start) exp_open = 1'b0;
      else if (start) exp_open = 1'b1;

      if (in_hs) begin
        b.data = s_axis.tdata;
        b.keep = s_axis.tkeep;
        b.last = s_axis.tlast;
        b.cyc  = cyc;
        expq.push_back(b);
      end

      prev_stall     = (m_axis.tvalid === 1'b1) && (m_axis.tready !== 1'b1);
      prev_beat.data = m_axis.tdata;
      prev_beat.keep = m_axis.tkeep;
      prev_beat.last = m_axis.tlast;
    end
  end

  task automatic idle_inputs();
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tkeep  = '0;
    start         = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    @(posedge aclk); #1;
    nrst = 1'b1;
    @(posedge aclk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge aclk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int g = 0;
    while (expq.size() != 0 && g < 60) begin
      @(posedge aclk); #1;
      g++;
    end
    nchk++;
    if (expq.size() != 0) begin
      nbad++;
      $display("FAIL %s_drain: got %0d beats left want 0", name, expq.size());
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    m_axis.tready = 1'b1;
    nrst = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    nchk++;
    if (m_axis.tvalid !== 1'b0 || m_axis.tdata !== '0 || m_axis.tkeep !== '0 || m_axis.tlast !== 1'b0) begin
      nbad++;
      $display("FAIL reset_m_bus: got v%0b %0h/%0h/%0b want all 0",
               m_axis.tvalid, m_axis.tdata, m_axis.tkeep, m_axis.tlast);
    end
    nchk++;
    if (frame_done !== 1'b0 || frame_cnt !== '0) begin
      nbad++;
      $display("FAIL reset_frame: got done=%0b cnt=%0d want 0 0", frame_done, frame_cnt);
    end
    nchk++;
    if (gate_open !== 1'b1 || s_axis.tready !== 1'b0) begin
      nbad++;
      $display("FAIL reset_gate: got open=%0b ready=%0b want 1 0", gate_open, s_axis.tready);
    end
    @(posedge aclk); #1;
    nrst = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    nchk++;
    if (s_axis.tready !== 1'b1) begin
      nbad++;
      $display("FAIL reset_first_ready: got %0b want 1", s_axis.tready);
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_latency();
    int done_seen = 0;
    lat_chk = 1'b1;
    m_axis.tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_axis.tdata  = DATA_W'(32'hA0 + i);
      s_axis.tkeep  = '1;
      s_axis.tlast  = (i == 3);
      s_axis.tvalid = 1'b1;
      @(negedge aclk);
      nchk++;
      if (s_axis.tready !== 1'b1) begin
        nbad++;
        $display("FAIL latency_in_ready: got %0b want 1 beat %0d", s_axis.tready, i);
      end
      @(posedge aclk); #1;
    end
    idle_inputs();
    repeat (12) begin
      @(negedge aclk);
      if (frame_done === 1'b1) done_seen++;
      @(posedge aclk); #1;
    end
    @(negedge aclk);
    nchk++;
    if (done_seen !== 1) begin
      nbad++;
      $display("FAIL latency_done_pulses: got %0d want 1", done_seen);
    end
    nchk++;
    if (frame_cnt !== CNT_W'(1)) begin
      nbad++;
      $display("FAIL latency_cnt: got %0d want 1", frame_cnt);
    end
    nchk++;
    if (gate_open !== 1'b0 || s_axis.tready !== 1'b0) begin
      nbad++;
      $display("FAIL latency_gate: got open=%0b ready=%0b want 0 0", gate_open, s_axis.tready);
    end
    @(posedge aclk); #1;
    drain("latency");
    lat_chk = 1'b0;
  endtask

  task automatic test_gate_hold();
    int hs = 0;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = DATA_W'(32'h5A5A_0001);
    s_axis.tkeep  = '1;
    s_axis.tlast  = 1'b0;
    repeat (10) begin
      @(negedge aclk);
      if (s_axis.tready === 1'b1) hs++;
      @(posedge aclk); #1;
    end
    nchk++;
    if (hs !== 0) begin
      nbad++;
      $display("FAIL gate_hold_handshakes: got %0d want 0", hs);
    end
    s_axis.tvalid = 1'b0;
    pulse_start();
    @(negedge aclk);
    nchk++;
    if (s_axis.tready !== 1'b1 || gate_open !== 1'b1) begin
      nbad++;
      $display("FAIL gate_reopen: got ready=%0b open=%0b want 1 1", s_axis.tready, gate_open);
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int guard = 0;
    int out0 = nout;
    while (sent < 200 && guard < 5000) begin
      s_axis.tvalid = ($urandom_range(0, 3) != 0);
      s_axis.tdata  = DATA_W'($urandom);
      s_axis.tkeep  = ($urandom_range(0, 9) == 0) ? '0 : KEEP_W'($urandom);
      s_axis.tlast  = ($urandom_range(0, 7) == 0);
      start         = ($urandom_range(0, 3) == 0);
      m_axis.tready = ($urandom_range(0, 1) == 1);
      @(negedge aclk);
      if (s_axis.tvalid === 1'b1 && s_axis.tready === 1'b1) sent++;
      @(posedge aclk); #1;
      guard++;
    end
    idle_inputs();
    m_axis.tready = 1'b1;
    nchk++;
    if (sent !== 200) begin
      nbad++;
      $display("FAIL bp_sent: got %0d want 200", sent);
    end
    drain("bp");
    nchk++;
    if (nout - out0 !== 200) begin
      nbad++;
      $display("FAIL bp_out_count: got %0d want 200", nout - out0);
    end
  endtask

  task automatic test_simultaneous();
    pulse_start();
    m_axis.tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_axis.tdata  = DATA_W'(32'hC0 + i);
      s_axis.tkeep  = KEEP_W'(i + 1);
      s_axis.tlast  = (i == 1) || (i == 3);
      s_axis.tvalid = 1'b1;
      start         = (i == 1);
      @(negedge aclk);
      nchk++;
      if (s_axis.tready !== 1'b1 || gate_open !== 1'b1) begin
        nbad++;
        $display("FAIL simul_no_gap: got ready=%0b open=%0b want 1 1 beat %0d",
                 s_axis.tready, gate_open, i);
      end
      @(posedge aclk); #1;
    end
    idle_inputs();
    @(negedge aclk);
    nchk++;
    if (gate_open !== 1'b0) begin
      nbad++;
      $display("FAIL simul_close: got open=%0b want 0", gate_open);
    end
    @(posedge aclk); #1;
    drain("simul");
    pulse_start();
  endtask

  task automatic test_wrap();
    int exp_seq[5] = '{1, 2, 3, 0, 1};
    do_reset();
    m_axis.tready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      int  g = 0;
      bit  got = 1'b0;
      logic [CNT_W-1:0] seen = '0;
      s_axis.tdata  = DATA_W'(32'hF0 + f);
      s_axis.tkeep  = '1;
      s_axis.tlast  = 1'b1;
      s_axis.tvalid = 1'b1;
      @(posedge aclk); #1;
      idle_inputs();
      while (!got && g < 20) begin
        @(negedge aclk);
        if (frame_done === 1'b1) begin
          got  = 1'b1;
          seen = frame_cnt;
        end
        @(posedge aclk); #1;
        g++;
      end
      nchk++;
      if (!got || seen !== CNT_W'(exp_seq[f])) begin
        nbad++;
        $display("FAIL wrap_cnt: got done=%0b cnt=%0d want done=1 cnt=%0d frame %0d",
                 got, seen, exp_seq[f], f);
      end
      pulse_start();
    end
  endtask

  task automatic test_async_reset();
    m_axis.tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_axis.tdata  = DATA_W'(32'hD0 + i);
      s_axis.tkeep  = '1;
      s_axis.tlast  = 1'b0;
      s_axis.tvalid = 1'b1;
      @(posedge aclk); #1;
    end
    nchk++;
    if (m_axis.tvalid !== 1'b1) begin
      nbad++;
      $display("FAIL arst_pre_valid: got %0b want 1", m_axis.tvalid);
    end
    #1;
    nrst = 1'b0;
    #1;
    nchk++;
    if (m_axis.tvalid !== 1'b0 || frame_cnt !== '0 || m_axis.tdata !== '0 || frame_done !== 1'b0) begin
      nbad++;
      $display("FAIL arst_immediate: got v=%0b cnt=%0d data=%0h done=%0b want 0 0 0 0",
               m_axis.tvalid, frame_cnt, m_axis.tdata, frame_done);
    end
    nchk++;
    if (gate_open !== 1'b1 || s_axis.tready !== 1'b0) begin
      nbad++;
      $display("FAIL arst_gate: got open=%0b ready=%0b want 1 0", gate_open, s_axis.tready);
    end
    idle_inputs();
    @(posedge aclk); #1;
    nrst = 1'b1;
    @(posedge aclk); #1;
    lat_chk = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_axis.tdata  = DATA_W'(32'hE0 + i);
      s_axis.tkeep  = '0;
      s_axis.tlast  = (i == 1);
      s_axis.tvalid = 1'b1;
      @(posedge aclk); #1;
    end
    idle_inputs();
    drain("arst");
    repeat (2) @(posedge aclk);
    #1;
    nchk++;
    if (frame_cnt !== CNT_W'(1)) begin
      nbad++;
      $display("FAIL arst_post_cnt: got %0d want 1", frame_cnt);
    end
    lat_chk = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    m_axis.tready = 1'b0;
    test_reset();
    test_latency();
    test_gate_hold();
    test_backpressure();
    test_simultaneous();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
